fnd_scan_controller: RTL and testbench
======================================

Name: fnd_scan_controller

Overview:
Time-multiplexing controller for the 4-digit FND display, sitting directly upstream of the FND digit-select decoder.
- Divides the system clock into a per-digit scan tick.
- Steps a 2-bit digit index and drives the matching BCD nibble out to the segment decoder.
- Computes a blank flag from display-off, blink, leading-zero suppression and invalid-BCD conditions.
- Drives the decoder's digit-select and enable inputs.
- Takes new values through a load strobe; commits them only at frame boundaries, so a frame never shows a torn value.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- SCAN_HZ, 1_000, per-digit scan rate; DIV = CLK_HZ/SCAN_HZ clocks per tick; DIV >= 2 is required.
- BLINK_TICKS, 500, scan ticks per blink half-period; >= 1.

Ports:
- i_clk, in, 1, system clock, rising edge.
- i_reset_n, in, 1, asynchronous active-low reset.
- i_bcd, in, 16, packed BCD value; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- i_load, in, 1, one-cycle strobe; captures i_bcd into the pending register.
- i_display_on, in, 1, 0 blanks all digits.
- i_blink, in, 1, 1 enables blinking of the whole display.
- i_lzb, in, 1, 1 enables leading-zero blanking.
- o_digitSelect, out, 2, digit index to the decoder's i_digitSelect.
- o_bcd, out, 4, nibble for the current digit, to the BCD-to-segment stage.
- o_blank, out, 1, to the decoder's i_en; 1 = all digits off.
- o_frame, out, 1, one-cycle pulse when a pending value is committed.
- o_err, out, 1, sticky: a nibble > 9 was committed.

Behaviour:
- Clock and reset (already decided): one clock, i_clk; i_reset_n asynchronous, active-low.
- Reset values:
  - o_digitSelect=0, o_bcd=0, o_blank=1, o_frame=0, o_err=0.
  - Prescaler=0, digit counter=0, blink counter=0, blink phase=on.
  - Active and pending registers=16'h0000; pending flag=0.
- Reset mid-operation: immediate return to the reset values above; any pending load is discarded.
- Prescaler:
  - Counts 0..DIV-1 and wraps to 0.
  - tick=1 for the single cycle in which the count equals DIV-1.
- Digit counter:
  - On tick, increments 0→1→2→3→0.
  - The 3→0 step is the frame boundary.
- Load:
  - i_load=1 latches i_bcd into pending and sets the pending flag.
  - A later load before commit overwrites pending (last value wins).
- Commit:
  - Occurs on a frame-boundary tick with the pending flag set.
  - Active ← pending, flag cleared, o_frame=1 next cycle.
  - o_err is set if any committed nibble > 9.
- Load coinciding with commit: the commit uses the old pending value. The new i_bcd is latched into pending with the flag left set, and commits at the next boundary.
- Blink:
  - Blink counter advances on each tick; it wraps after BLINK_TICKS ticks and toggles the phase.
  - The counter and phase run continuously.
  - With i_blink=0 the phase is ignored (display treated as on).
- Leading-zero blanking, with i_lzb=1:
  - Digit k (k = 3..1) is blanked if nibbles k..3 of the active value are all 0.
  - Digit 0 is never blanked by this rule.
- Output registers:
  - o_digitSelect, o_bcd and o_blank update together, registered, in the cycle after tick, using the new digit index and the post-commit active value.
  - Latency from tick to outputs: 1 clock.
  - o_bcd = active nibble[idx], passed through even when that digit is blanked.
- Blank equation: o_blank = ~i_display_on | (i_blink & phase_off) | lzb_blank(idx) | (nibble[idx] > 9).
- Live controls: i_display_on, i_blink and i_lzb are sampled at each output update, not continuously.

Decomposition:
- Package fnd_pkg:
  - Constants NUM_DIGITS=4, BCD_W=4, SEL_W=2.
  - Digit-index typedef.
  - Function for nibble extraction and the >9 check.
- Sub-module fnd_tick_gen: parameterised prescaler producing the one-cycle tick; reused by other display blocks.

Test Plan (DIV=4, BLINK_TICKS=8 unless stated):
- Reset then free run → o_digitSelect sequence 0,1,2,3,0 with exactly 4 clocks between changes; o_blank=1 throughout, because active=0000 with i_lzb=1 blanks digits 3..1, and digit 0 is blanked while i_display_on=0; o_blank drops on digit 0 once i_display_on=1.
- i_display_on=1, i_lzb=0, load 16'h1234 mid-frame → outputs keep 0000 until the next 3→0 boundary; o_frame pulses once; then (sel, bcd) = (0,4),(1,3),(2,2),(3,1) with o_blank=0.
- i_lzb=1, active 16'h0070 → digits 3 and 2 blanked; digit 1 (7) and digit 0 (0) shown; active 16'h0000 → only digit 0 shown.
- Load 16'h5555 then 16'h6666 before the boundary, plus 16'h7777 exactly on the commit cycle → commits 6666 with o_frame; 7777 commits at the following boundary with a second o_frame.
- i_blink=1 → o_blank forced to 1 for 8 ticks, released for 8 ticks, repeating; i_blink=0 restores normal display at the next update.
- Load 16'h12A4, commit → digit 1 blanked with o_bcd=4'hA and o_err=1; o_err holds after loading 16'h1234 and clears only when i_reset_n is asserted asynchronously mid-frame (all outputs return to reset values immediately).

Source files
------------

// File: rtl/fnd_pkg.sv
// -----------------------------------------------------------------------------
// fnd_pkg
// Shared types, constants and helpers for the 4-digit FND display blocks.
//   - digit_idx_t   : index of one of the NUM_DIGITS digits
//   - nibble_t      : one BCD digit
//   - blink_phase_t : on/off half of the blink period
//   - get_nibble    : extract digit idx from a packed BCD value
//   - nibble_invalid: nibble outside 0..9
//   - any_invalid   : any digit of a packed value outside 0..9
//   - lzb_blank     : digit idx and every digit above it are zero
// -----------------------------------------------------------------------------
package fnd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4;
    localparam int SEL_W      = 2;
    localparam int VALUE_W    = NUM_DIGITS * BCD_W;

    typedef logic [SEL_W-1:0]   digit_idx_t;
    typedef logic [BCD_W-1:0]   nibble_t;
    typedef logic [VALUE_W-1:0] bcd_value_t;

    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } blink_phase_t;

    localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

    function automatic nibble_t get_nibble(input bcd_value_t value, input digit_idx_t idx);
        return value[int'(idx)*BCD_W +: BCD_W];
    endfunction

    function automatic logic nibble_invalid(input nibble_t nibble);
        return nibble > nibble_t'(9);
    endfunction

    function automatic logic any_invalid(input bcd_value_t value);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (nibble_invalid(value[k*BCD_W +: BCD_W])) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Digit 0 is never a leading zero; higher digits blank only when they and
    // every digit to their left are zero.
    function automatic logic lzb_blank(input bcd_value_t value, input digit_idx_t idx);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && value[k*BCD_W +: BCD_W] != '0) begin
                upper_zero = 1'b0;
            end
        end
        return (idx != '0) && upper_zero;
    endfunction

endpackage

// File: rtl/fnd_tick_gen.sv
// -----------------------------------------------------------------------------
// fnd_tick_gen
// Free-running prescaler: counts 0..DIV-1 and asserts o_tick for the single
// cycle in which the count equals DIV-1.
//   i_clk     : system clock, rising edge
//   i_reset_n : asynchronous active-low reset (count returns to 0)
//   o_tick    : one-cycle pulse every DIV clocks
// -----------------------------------------------------------------------------
module fnd_tick_gen #(
    parameter int DIV = 100_000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    output logic o_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == CNT_LAST);
    assign o_tick = w_tick;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// -----------------------------------------------------------------------------
// fnd_scan_controller
// Time-multiplexes a 4-digit packed BCD value onto the FND decoder. A new value
// is captured by i_load into a pending register and only becomes active at the
// digit 3 -> 0 step, so one frame never mixes two values.
//   i_clk, i_reset_n : clock / asynchronous active-low reset
//   i_bcd, i_load    : packed BCD value and its one-cycle capture strobe
//   i_display_on     : 0 blanks every digit
//   i_blink          : 1 blanks the whole display during the off blink phase
//   i_lzb            : 1 enables leading-zero blanking
//   o_digitSelect    : current digit index to the decoder
//   o_bcd            : nibble of the current digit (even when blanked)
//   o_blank          : decoder enable, 1 = dark
//   o_frame          : one-cycle pulse after a pending value is committed
//   o_err            : sticky, a committed nibble was above 9
// -----------------------------------------------------------------------------
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 1_000,
    parameter int BLINK_TICKS = 500
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [VALUE_W-1:0] i_bcd,
    input  logic               i_load,
    input  logic               i_display_on,
    input  logic               i_blink,
    input  logic               i_lzb,
    output logic [SEL_W-1:0]   o_digitSelect,
    output logic [BCD_W-1:0]   o_bcd,
    output logic               o_blank,
    output logic               o_frame,
    output logic               o_err
);

    localparam int DIV     = CLK_HZ / SCAN_HZ;
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    // Scan state
    logic                 w_tick;
    digit_idx_t           r_idx;
    bcd_value_t           r_active;
    bcd_value_t           r_pending;
    logic                 r_pend_flag;
    logic [BLINK_W-1:0]   r_blink_cnt;
    blink_phase_t         r_phase;

    // Registered outputs
    digit_idx_t           r_sel;
    nibble_t              r_bcd;
    logic                 r_blank;
    logic                 r_frame;
    logic                 r_err;

    // Next-state view used by the output registers
    digit_idx_t           w_next_idx;
    logic                 w_commit;
    bcd_value_t           w_next_active;
    logic                 w_blink_wrap;
    blink_phase_t         w_next_phase;
    nibble_t              w_next_nibble;
    logic                 w_next_blank;

    fnd_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .o_tick    (w_tick)
    );

    // Outputs are built from the values the state takes at this tick edge, so
    // the new digit and a freshly committed value appear together one clock
    // after the tick.
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        w_next_idx    = r_idx;
        w_commit      = 1'b0;
        w_next_active = r_active;
        w_blink_wrap  = 1'b0;
        w_next_phase  = r_phase;

        if (w_tick) begin
            w_next_idx   = r_idx + digit_idx_t'(1);
            w_commit     = (r_idx == LAST_DIGIT) && r_pend_flag;
            w_blink_wrap = (r_blink_cnt == BLINK_LAST);
        end
        if (w_commit) begin
            w_next_active = r_pending;
        end
        if (w_blink_wrap) begin
            w_next_phase = (r_phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
        end

        w_next_nibble = get_nibble(w_next_active, w_next_idx);
        w_next_blank  = ~i_display_on
                      | (i_blink & (w_next_phase == PHASE_OFF))
                      | (i_lzb & lzb_blank(w_next_active, w_next_idx))
                      | nibble_invalid(w_next_nibble);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_idx       <= '0;
            r_active    <= '0;
            r_pending   <= '0;
            r_pend_flag <= 1'b0;
            r_blink_cnt <= '0;
            r_phase     <= PHASE_ON;
            r_sel       <= '0;
            r_bcd       <= '0;
            r_blank     <= 1'b1;
            r_frame     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_active <= w_next_active;
            r_phase  <= w_next_phase;
            r_frame  <= w_commit;
            r_err    <= r_err | (w_commit & any_invalid(r_pending));

            // A load on the commit edge lands in pending after the old value
            // has been committed, and keeps the flag set for the next frame.
            if (i_load) begin
                r_pending   <= i_bcd;
                r_pend_flag <= 1'b1;
            end else if (w_commit) begin
                r_pend_flag <= 1'b0;
            end

            if (w_tick) begin
                r_idx       <= w_next_idx;
                r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BLINK_W'(1);
                r_sel       <= w_next_idx;
                r_bcd       <= w_next_nibble;
                r_blank     <= w_next_blank;
            end
        end
    end

    assign o_digitSelect = r_sel;
    assign o_bcd         = r_bcd;
    assign o_blank       = r_blank;
    assign o_frame       = r_frame;
    assign o_err         = r_err;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_fnd_scan_controller
// Runs the scan controller with DIV=4, BLINK_TICKS=8 through directed scenes
// and a randomized stretch, comparing every output after every clock against a
// reference model built on clock/tick arithmetic since reset.
// -----------------------------------------------------------------------------
module tb_fnd_scan_controller;

    localparam int CLK_HZ      = 4_000;
    localparam int SCAN_HZ     = 1_000;
    localparam int DIV         = CLK_HZ / SCAN_HZ;
    localparam int BLINK_TICKS = 8;
    localparam int FRAME_CLKS  = 4 * DIV;

    logic        clk;
    logic        rst_n;
    logic [15:0] i_bcd;
    logic        i_load;
    logic        i_display_on;
    logic        i_blink;
    logic        i_lzb;
    logic [1:0]  o_digitSelect;
    logic [3:0]  o_bcd;
    logic        o_blank;
    logic        o_frame;
    logic        o_err;

    fnd_scan_controller #(
        .CLK_HZ      (CLK_HZ),
        .SCAN_HZ     (SCAN_HZ),
        .BLINK_TICKS (BLINK_TICKS)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_bcd         (i_bcd),
        .i_load        (i_load),
        .i_display_on  (i_display_on),
        .i_blink       (i_blink),
        .i_lzb         (i_lzb),
        .o_digitSelect (o_digitSelect),
        .o_bcd         (o_bcd),
        .o_blank       (o_blank),
        .o_frame       (o_frame),
        .o_err         (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int          edges;
    logic [15:0] m_active;
    logic [15:0] m_pending;
    bit          m_flag;
    bit          m_err;
    logic [1:0]  e_sel;
    logic [3:0]  e_bcd;
    bit          e_blank;
    bit          e_frame;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, edges, $time);
        end
    endtask

    function automatic void model_reset();
        edges     = 0;
        m_active  = '0;
        m_pending = '0;
        m_flag    = 1'b0;
        m_err     = 1'b0;
        e_sel     = '0;
        e_bcd     = '0;
        e_blank   = 1'b1;
        e_frame   = 1'b0;
    endfunction

    // One rising edge: tick number t = edges/DIV, digit = t mod 4,
    // blink half-period number = t / BLINK_TICKS.
    function automatic void model_edge();
        int t, idx, act, nib;
        bit phase_off, lz;
        edges++;
        e_frame = 1'b0;
        if (edges % DIV == 0) begin
            t   = edges / DIV;
            idx = t % 4;
            if (idx == 0 && m_flag) begin
                m_active = m_pending;
                m_flag   = 1'b0;
                e_frame  = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    if (((int'(m_pending) >> (4*k)) & 15) > 9) m_err = 1'b1;
                end
            end
            act       = int'(m_active);
            nib       = (act >> (4*idx)) & 15;
            phase_off = ((t / BLINK_TICKS) % 2) == 1;
            lz        = i_lzb && idx != 0 && (act >> (4*idx)) == 0;
            e_sel     = 2'(idx);
            e_bcd     = 4'(nib);
            e_blank   = !i_display_on || (i_blink && phase_off) || lz || nib > 9;
        end
        if (i_load) begin
            m_pending = i_bcd;
            m_flag    = 1'b1;
        end
    endfunction

    // Called at a falling edge; inputs set beforehand are sampled at the next
    // rising edge, outputs are compared at the following falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("digitSelect", 32'(o_digitSelect), 32'(e_sel));
        check("bcd",         32'(o_bcd),         32'(e_bcd));
        check("blank",       32'(o_blank),       32'(e_blank));
        check("frame",       32'(o_frame),       32'(e_frame));
        check("err",         32'(o_err),         32'(m_err));
        i_load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [15:0] value);
        i_bcd  = value;
        i_load = 1'b1;
        step();
    endtask

    // Called at a falling edge; asserts reset between edges and checks that
    // outputs return to reset values without waiting for a clock.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_digitSelect", 32'(o_digitSelect), 32'd0);
        check("rst_bcd",         32'(o_bcd),         32'd0);
        check("rst_blank",       32'(o_blank),       32'd1);
        check("rst_frame",       32'(o_frame),       32'd0);
        check("rst_err",         32'(o_err),         32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [15:0] rand_value();
        logic [15:0] v;
        if ($urandom_range(0, 3) != 0) begin
            for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 1) v[15:8] = 8'h00;
        end else begin
            v = 16'($urandom());
        end
        return v;
    endfunction

    initial begin
        rst_n        = 1'b0;
        i_bcd        = '0;
        i_load       = 1'b0;
        i_display_on = 1'b0;
        i_blink      = 1'b0;
        i_lzb        = 1'b1;
        model_reset();

        // Free run from reset: dark until the display is switched on
        @(negedge clk);
        do_reset();
        run(24);
        i_display_on = 1'b1;
        run(20);

        // Mid-frame load of 1234 waits for the frame boundary
        i_lzb = 1'b0;
        run(6);
        load(16'h1234);
        run(40);

        // Leading-zero blanking
        i_lzb = 1'b1;
        load(16'h0070);
        run(40);
        load(16'h0000);
        run(40);

        // Last load wins; a load on the commit edge waits a frame
        while ((edges + 8) % FRAME_CLKS != 0) step();
        load(16'h5555);
        load(16'h6666);
        while ((edges + 1) % FRAME_CLKS != 0) step();
        load(16'h7777);
        run(2 * FRAME_CLKS + 4);

        // Blink
        i_lzb   = 1'b0;
        i_blink = 1'b1;
        run(5 * BLINK_TICKS * DIV);
        i_blink = 1'b0;
        run(20);

        // Invalid nibble and sticky error, cleared by a mid-frame reset
        load(16'h12A4);
        run(40);
        load(16'h1234);
        run(40);
        run(6);
        do_reset();
        run(20);

        // Randomized operation
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                i_bcd  = rand_value();
                i_load = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) i_display_on = ~i_display_on;
            if ($urandom_range(0, 39) == 0) i_blink      = ~i_blink;
            if ($urandom_range(0, 29) == 0) i_lzb        = ~i_lzb;
            if ($urandom_range(0, 599) == 0) begin
                i_load = 1'b0;
                do_reset();
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
